// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 64;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and word-write output of the instruction-memory loader.
interface imem_loader_if
  import imem_loader_pkg::*;
();

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // master: byte source and memory sink; slave: the loader
  modport master (
    output byte_data, byte_valid, byte_last,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_data, byte_valid, byte_last,
    output byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Shifts stream bytes into a big-endian word; word_o is the word including the byte
// being pushed this cycle, zero-padded in its low bytes when the word is partial.
module imem_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [31:0] shreg_q, shreg_d;
  logic [2:0]  idx_q, idx_d;

  always_comb begin
    shreg_d = {shreg_q[23:0], byte_i};
    idx_d   = idx_q + 3'd1;
    // Stale bytes from the previous word sit above the new ones and are dropped here
    case (idx_d)
      3'd1:    word_o = {shreg_d[7:0], 24'h0};
      3'd2:    word_o = {shreg_d[15:0], 16'h0};
      3'd3:    word_o = {shreg_d[23:0], 8'h0};
      default: word_o = shreg_d;
    endcase
    word_complete_o = push_i && ((idx_q == 3'd3) || last_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      idx_q   <= '0;
    end else if (push_i) begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-stream program image into instruction memory as big-endian words,
// holding the CPU until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  imem_loader_if.slave      bus,
  output logic [15:0]       word_count_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  // One extra bit so the bounds check cannot wrap near the top of the address space
  localparam logic [ADDR_W:0] MemLimit = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] LastOfs  = (ADDR_W + 1)'(WORD_BYTES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [15:0]       word_count_q;
  logic              last_q, byte_ready_q, wr_en_q, cpu_hold_q, done_q, error_q;

  logic              xfer, can_start, pk_clear, fits, word_complete;
  logic [31:0]       word;

  assign xfer      = bus.byte_valid && byte_ready_q;
  assign can_start = start_i && (state_q inside {StIdle, StDone, StError});
  assign pk_clear  = can_start || (state_q == StWrite);
  assign fits      = ({1'b0, cur_addr_q} + LastOfs) < MemLimit;

  imem_byte_packer u_packer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (pk_clear),
    .push_i          (xfer),
    .byte_i          (bus.byte_data),
    .last_i          (bus.byte_last),
    .word_o          (word),
    .word_complete_o (word_complete)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cur_addr_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      last_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StError: begin
          if (start_i) begin
            cur_addr_q   <= {base_addr_i[ADDR_W-1:2], 2'b00};
            word_count_q <= '0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            byte_ready_q <= 1'b1;
            state_q      <= StCollect;
          end
        end
        StCollect: begin
          if (xfer) begin
            last_q <= bus.byte_last;
            if (word_complete) begin
              byte_ready_q <= 1'b0;
              state_q      <= StWrite;
              if (fits) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cur_addr_q;
                wr_data_q <= word;
              end
            end
          end
        end
        StWrite: begin
          // wr_en_q high here means the bounds check passed on entry
          if (wr_en_q) begin
            cur_addr_q   <= cur_addr_q + ADDR_W'(WORD_BYTES);
            word_count_q <= word_count_q + 16'd1;
            if (last_q) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= StDone;
            end else begin
              byte_ready_q <= 1'b1;
              state_q      <= StCollect;
            end
          end else begin
            error_q <= 1'b1;
            state_q <= StError;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign word_count_o   = word_count_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 256-byte and an 8-byte instance share one stimulus stream
// and are scored against a word-level model of the loaded image.
module tb_imem_loader;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef wr_t        wr_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic [7:0]  byte_data_r = '0;
  logic        byte_valid_r = 1'b0;
  logic        byte_last_r = 1'b0;

  logic [15:0] wc_big, wc_small;
  logic        hold_big, hold_small, done_big, done_small, err_big, err_small;

  int vecs = 0;
  int errs = 0;
  wr_q_t exp_big, exp_small, obs_big;

  imem_loader_if big_if ();
  imem_loader_if small_if ();

  assign big_if.byte_data    = byte_data_r;
  assign big_if.byte_valid   = byte_valid_r;
  assign big_if.byte_last    = byte_last_r;
  assign small_if.byte_data  = byte_data_r;
  assign small_if.byte_valid = byte_valid_r;
  assign small_if.byte_last  = byte_last_r;

  imem_loader #(.MEM_BYTES(256)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .bus          (big_if.slave),
    .word_count_o (wc_big),
    .cpu_hold_o   (hold_big),
    .done_o       (done_big),
    .error_o      (err_big)
  );

  imem_loader #(.MEM_BYTES(8)) u_small (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .bus          (small_if.slave),
    .word_count_o (wc_small),
    .cpu_hold_o   (hold_small),
    .done_o       (done_small),
    .error_o      (err_small)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Image-level model: words of 4 bytes, MSB first, at consecutive aligned addresses
  task automatic model_load(input logic [63:0] base, input byte_q_t b, input bit last,
                            input int unsigned mem, output wr_q_t wq, output int cnt,
                            output bit er, output bit fin);
    logic [63:0] a;
    int          nb;
    a   = {base[63:2], 2'b00};
    cnt = 0; er = 0; fin = 0; wq = {};
    nb  = b.size();
    for (int i = 0; i < nb; i += 4) begin
      int          n;
      logic [31:0] w;
      wr_t         e;
      n = (nb - i < 4) ? nb - i : 4;
      if (n < 4 && !last) break;
      w = '0;
      for (int k = 0; k < n; k++) w[31-8*k -: 8] = b[i+k];
      if (a + 64'd3 >= 64'(mem)) begin
        er = 1;
        break;
      end
      e.addr = a; e.data = w;
      wq.push_back(e);
      a += 64'd4;
      cnt++;
      if (last && (i + n == nb)) fin = 1;
    end
  endtask

  task automatic check_wr(input bit sel, input logic [63:0] a, input logic [31:0] d,
                          input logic rdy);
    wr_t   e, o;
    string n = sel ? "small" : "big";
    chk({n, "_ready_during_write"}, {63'd0, rdy}, 64'd0);
    vecs++;
    if ((sel ? exp_small.size() : exp_big.size()) == 0) begin
      errs++;
      $display("FAIL %s_unexpected_write: actual addr %h data %h, required no write", n, a, d);
      return;
    end
    e = sel ? exp_small.pop_front() : exp_big.pop_front();
    if (!sel) begin
      o.addr = a; o.data = d;
      obs_big.push_back(o);
    end
    if (a !== e.addr || d !== e.data) begin
      errs++;
      $display("FAIL %s_write: actual %h/%h required %h/%h", n, a, d, e.addr, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (big_if.wr_en)   check_wr(1'b0, big_if.wr_addr, big_if.wr_data, big_if.byte_ready);
      if (small_if.wr_en) check_wr(1'b1, small_if.wr_addr, small_if.wr_data,
                                   small_if.byte_ready);
    end
  end

  // mode 0: valid always; 1: valid toggles every cycle; 2: random bubbles
  task automatic run_load(input logic [63:0] base, input byte_q_t b, input bit last,
                          input int mode);
    wr_q_t wq;
    int    cnt_b, cnt_s;
    bit    er_b, fin_b, er_s, fin_s, ph, abort;
    model_load(base, b, last, 256, wq, cnt_b, er_b, fin_b);
    foreach (wq[i]) exp_big.push_back(wq[i]);
    model_load(base, b, last, 8, wq, cnt_s, er_s, fin_s);
    foreach (wq[i]) exp_small.push_back(wq[i]);
    obs_big.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    ph = 1'b0; abort = 1'b0;
    for (int i = 0; i < b.size() && !abort && !err_big; i++) begin
      bit x = 1'b0;
      int guard = 0;
      byte_data_r = b[i];
      byte_last_r = last && (i == b.size() - 1);
      while (!x && !err_big) begin
        case (mode)
          0:       byte_valid_r = 1'b1;
          1:       begin byte_valid_r = ph; ph = !ph; end
          default: byte_valid_r = ($urandom_range(0, 3) != 0);
        endcase
        @(negedge clk);
        x = byte_valid_r && big_if.byte_ready;
        @(posedge clk); #1;
        if (++guard > 50) begin
          chk("byte_accept_timeout", 64'd0, 64'd1);
          abort = 1'b1;
          break;
        end
      end
    end
    byte_valid_r = 1'b0; byte_last_r = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("big_done", {63'd0, done_big}, {63'd0, fin_b});
    chk("big_error", {63'd0, err_big}, {63'd0, er_b});
    chk("big_cpu_hold", {63'd0, hold_big}, {63'd0, !fin_b});
    chk("big_word_count", {48'd0, wc_big}, 64'(cnt_b));
    chk("big_pending_writes", 64'(exp_big.size()), 64'd0);
    chk("small_done", {63'd0, done_small}, {63'd0, fin_s});
    chk("small_error", {63'd0, err_small}, {63'd0, er_s});
    chk("small_cpu_hold", {63'd0, hold_small}, {63'd0, !fin_s});
    chk("small_word_count", {48'd0, wc_small}, 64'(cnt_s));
    chk("small_pending_writes", 64'(exp_small.size()), 64'd0);
    exp_big.delete(); exp_small.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, {63'd0, big_if.byte_ready}, 64'd0);
    chk({tag, "_wr_en"}, {63'd0, big_if.wr_en}, 64'd0);
    chk({tag, "_wr_addr"}, big_if.wr_addr, 64'd0);
    chk({tag, "_wr_data"}, {32'd0, big_if.wr_data}, 64'd0);
    chk({tag, "_word_count"}, {48'd0, wc_big}, 64'd0);
    chk({tag, "_cpu_hold"}, {63'd0, hold_big}, 64'd0);
    chk({tag, "_done"}, {63'd0, done_big}, 64'd0);
    chk({tag, "_error"}, {63'd0, err_big}, 64'd0);
    chk({tag, "_small_error"}, {63'd0, err_small}, 64'd0);
  endtask

  initial begin
    byte_q_t q;
    wr_q_t   wq;
    int      cnt;
    bit      er, fin;

    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    q = '{8'hF8, 8'h42, 8'h80, 8'h05};
    model_load(64'h0, q, 1'b1, 256, wq, cnt, er, fin);
    chk("model_t1_data", {32'd0, wq[0].data}, 64'hF842_8005);
    run_load(64'h0, q, 1'b1, 0);
    chk("t1_write_count", 64'(obs_big.size()), 64'd1);
    chk("t1_addr", obs_big[0].addr, 64'h0);
    chk("t1_data", {32'd0, obs_big[0].data}, 64'hF842_8005);

    q = '{8'hB4, 8'h00, 8'h00, 8'h9F, 8'hF8, 8'h00, 8'h80, 8'h01};
    run_load(64'h18, q, 1'b1, 0);
    chk("t2_addr0", obs_big[0].addr, 64'h18);
    chk("t2_data0", {32'd0, obs_big[0].data}, 64'hB400_009F);
    chk("t2_addr1", obs_big[1].addr, 64'h1C);
    chk("t2_data1", {32'd0, obs_big[1].data}, 64'hF800_8001);
    chk("t2_word_count", {48'd0, wc_big}, 64'd2);

    q = '{8'h8A, 8'h0A};
    run_load(64'h0, q, 1'b1, 0);
    chk("t3_data", {32'd0, obs_big[0].data}, 64'h8A0A_0000);
    chk("t3_done", {63'd0, done_big}, 64'd1);

    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(64'h43, q, 1'b1, 1);
    chk("t4_write_count", 64'(obs_big.size()), 64'd1);
    chk("t4_addr", obs_big[0].addr, 64'h40);
    chk("t4_data", {32'd0, obs_big[0].data}, 64'h1234_5678);

    for (int t = 0; t < 10; t++) begin
      int n = $urandom_range(1, 12);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      run_load(64'($urandom_range(0, 255)), q, 1'b1, 2);
    end

    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model_load(64'h4, q, 1'b0, 8, wq, cnt, er, fin);
    chk("model_t5_writes", 64'(wq.size()), 64'd1);
    chk("model_t5_error", {63'd0, er}, 64'd1);
    run_load(64'h4, q, 1'b0, 0);
    chk("t5_small_error", {63'd0, err_small}, 64'd1);
    chk("t5_small_hold", {63'd0, hold_small}, 64'd1);

    @(posedge clk); #1;
    rst = 1'b1; #2;
    check_reset_outputs("rst_after_overflow");
    @(posedge clk); #1;
    rst = 1'b0;

    q = '{8'hEE, 8'hDD};
    run_load(64'h20, q, 1'b0, 0);
    rst = 1'b1; #2;
    check_reset_outputs("rst_mid_load");
    @(posedge clk); #1;
    rst = 1'b0;
    q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load(64'h20, q, 1'b1, 0);
    chk("t6_addr", obs_big[0].addr, 64'h20);
    chk("t6_data", {32'd0, obs_big[0].data}, 64'hA1B2_C3D4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
